// File: rtl/mem_access.sv
// Load/store stage: drives a 32-bit word bus with valid/ready, splits misaligned
// accesses into two beats and returns extended load data as a writeback pulse.
module mem_access (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_ld_i,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [4:0]  req_rd_i,
  output logic        req_ready_o,
  output logic        bus_valid_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ0 = 3'd1;
  localparam logic [2:0] S_RSP0 = 3'd2;
  localparam logic [2:0] S_REQ1 = 3'd3;
  localparam logic [2:0] S_RSP1 = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        ld_q, ld_d, uns_q, uns_d, split_q, split_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] data_q, data_d, r0_q, r0_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d, we_q, we_d;
  logic [31:0] baddr_q, baddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wb_en_q, wb_en_d, err_q, err_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fin;
  logic [31:0] fin_raw;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] r1, input logic [31:0] r0,
                                        input logic [1:0] off);
    logic [63:0] both;
    both = {r1, r0} >> {off, 3'b000};
    return both[31:0];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    logic signed [31:0] sb, sh;
    sb = 32'(signed'(raw[7:0]));
    sh = 32'(signed'(raw[15:0]));
    case (size)
      2'd0:    return uns ? {24'b0, raw[7:0]} : sb;
      2'd1:    return uns ? {16'b0, raw[15:0]} : sh;
      default: return raw;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;  ld_d = ld_q;  uns_d = uns_q;  split_d = split_q;
    size_d = size_q;  off_d = off_q;  data_d = data_q;  rd_d = rd_q;  r0_d = r0_q;
    valid_d = valid_q;  we_d = we_q;  baddr_d = baddr_q;
    wstrb_d = wstrb_q;  wdata_d = wdata_q;
    wb_en_d = 1'b0;  wb_addr_d = wb_addr_q;  wb_data_d = wb_data_q;  err_d = 1'b0;
    fin = 1'b0;  fin_raw = '0;
    case (state_q)
      S_IDLE: begin
        if (req_ld_i || req_wr_i) begin
          if (req_size_i == 2'd3 || (req_ld_i && req_wr_i)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_REQ0;
            ld_d    = req_ld_i;
            uns_d   = req_unsigned_i;
            size_d  = req_size_i;
            off_d   = req_addr_i[1:0];
            data_d  = req_data_i;
            rd_d    = req_rd_i;
            r0_d    = '0;
            split_d = (req_size_i == 2'd1 && req_addr_i[1:0] == 2'd3) ||
                      (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0);
            valid_d = 1'b1;
            we_d    = req_wr_i;
            baddr_d = {req_addr_i[31:2], 2'b00};
            wstrb_d = req_wr_i ? size_mask(req_size_i) << req_addr_i[1:0] : 4'b0000;
            wdata_d = req_wr_i ? req_data_i << {req_addr_i[1:0], 3'b000} : 32'd0;
          end
        end
      end
      S_REQ0: begin
        if (bus_ready_i) begin
          if (ld_q) begin
            state_d = S_RSP0;
            valid_d = 1'b0;
          end else if (split_q) begin
            // Second store beat follows back-to-back with the upper bytes.
            state_d = S_REQ1;
            baddr_d = baddr_q + 32'd4;
            wstrb_d = size_mask(size_q) >> (3'd4 - {1'b0, off_q});
            wdata_d = data_q >> (6'd32 - {1'b0, off_q, 3'b000});
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      S_RSP0: begin
        if (bus_rvalid_i) begin
          r0_d = bus_rdata_i;
          if (split_q) begin
            state_d = S_REQ1;
            valid_d = 1'b1;
            baddr_d = baddr_q + 32'd4;
          end else begin
            fin     = 1'b1;
            fin_raw = merge(32'd0, bus_rdata_i, off_q);
          end
        end
      end
      S_REQ1: begin
        if (bus_ready_i) begin
          valid_d = 1'b0;
          state_d = ld_q ? S_RSP1 : S_IDLE;
        end
      end
      S_RSP1: begin
        if (bus_rvalid_i) begin
          fin     = 1'b1;
          fin_raw = merge(bus_rdata_i, r0_q, off_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d   = S_IDLE;
      wb_en_d   = (rd_q != 5'd0);
      wb_addr_d = rd_q;
      wb_data_d = extend(fin_raw, size_q, uns_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  ld_q <= 1'b0;  uns_q <= 1'b0;  split_q <= 1'b0;
      size_q <= '0;  off_q <= '0;  data_q <= '0;  rd_q <= '0;  r0_q <= '0;
      valid_q <= 1'b0;  we_q <= 1'b0;  baddr_q <= '0;  wstrb_q <= '0;  wdata_q <= '0;
      wb_en_q <= 1'b0;  wb_addr_q <= '0;  wb_data_q <= '0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  ld_q <= ld_d;  uns_q <= uns_d;  split_q <= split_d;
      size_q <= size_d;  off_q <= off_d;  data_q <= data_d;  rd_q <= rd_d;  r0_q <= r0_d;
      valid_q <= valid_d;  we_q <= we_d;  baddr_q <= baddr_d;
      wstrb_q <= wstrb_d;  wdata_q <= wdata_d;
      wb_en_q <= wb_en_d;  wb_addr_q <= wb_addr_d;  wb_data_q <= wb_data_d;  err_q <= err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign bus_valid_o = valid_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = baddr_q;
  assign bus_wstrb_o = wstrb_q;
  assign bus_wdata_o = wdata_q;
  assign wb_en_o     = wb_en_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-addressed memory model behind a bus responder,
// directed cases followed by randomized load/store traffic.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_ld_i = 1'b0, req_wr_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic [31:0] req_addr_i = '0, req_data_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        req_ready_o, bus_valid_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_ready_i = 1'b1, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        wb_en_o, err_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk_i(clk), .rst_i(rst_i), .req_ld_i(req_ld_i), .req_wr_i(req_wr_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_rd_i(req_rd_i), .req_ready_o(req_ready_o),
    .bus_valid_o(bus_valid_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_wdata_o(bus_wdata_o), .bus_ready_i(bus_ready_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .wb_en_o(wb_en_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } beat_t;

  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  beat_t beats[$];
  int checks = 0, errors = 0;
  int wb_cnt = 0, err_cnt = 0, hold_cnt = 0;
  logic hold_bad = 1'b0;
  int hold_gen = 0, hold_n = 0;
  int rsp_delay = 0;
  logic rand_rdy = 1'b0, rand_lat = 1'b0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Memory-backed bus slave: records beats, applies writes, answers reads.
  initial begin : responder
    logic rsp_pend, prev_stall;
    int rsp_wait, hold_seen, hold_left;
    logic [31:0] rsp_word;
    logic [68:0] snap;
    rsp_pend = 0; prev_stall = 0; rsp_wait = 0; hold_seen = 0; hold_left = 0;
    rsp_word = '0; snap = '0;
    forever begin
      @(posedge clk);
      if (bus_rvalid_i) rsp_pend = 0;
      if (rst_i) prev_stall = 0;
      else begin
        if (bus_valid_o && prev_stall) begin
          hold_cnt++;
          if ({bus_addr_o, bus_we_o, bus_wstrb_o, bus_wdata_o} !== snap) hold_bad = 1'b1;
        end
        if (bus_valid_o && bus_ready_i) begin
          beats.push_back('{bus_addr_o, bus_we_o, bus_wstrb_o, bus_wdata_o});
          if (bus_we_o) begin
            for (int l = 0; l < 4; l++)
              if (bus_wstrb_o[l]) bus_mem[bus_addr_o + 32'(l)] = bus_wdata_o[8*l +: 8];
          end else begin
            rsp_pend = 1;
            rsp_wait = rand_lat ? $urandom_range(0, 3) : rsp_delay;
            rsp_word = {bus_rd(bus_addr_o + 32'd3), bus_rd(bus_addr_o + 32'd2),
                        bus_rd(bus_addr_o + 32'd1), bus_rd(bus_addr_o)};
          end
        end
        prev_stall = bus_valid_o && !bus_ready_i;
        snap = {bus_addr_o, bus_we_o, bus_wstrb_o, bus_wdata_o};
      end
      if (wb_en_o) wb_cnt++;
      if (err_o) err_cnt++;
      @(negedge clk);
      if (hold_gen != hold_seen) begin hold_seen = hold_gen; hold_left = hold_n; end
      if (hold_left > 0) begin bus_ready_i = 1'b0; hold_left--; end
      else bus_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_pend && rsp_wait == 0) begin
        bus_rvalid_i = 1'b1; bus_rdata_i = rsp_word;
      end else begin
        if (rsp_pend) rsp_wait--;
        bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] size,
                                           input logic uns);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic do_req(input logic ld, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, output int lat, output logic wbe,
                        output logic err1, output logic vld1, output logic [4:0] wba,
                        output logic [31:0] wbd);
    int n;
    n = 0;
    while (!req_ready_o && n < 500) begin @(negedge clk); n++; end
    if (!req_ready_o) chk("idle_timeout", 32'(req_ready_o), 32'd1);
    req_ld_i = ld; req_wr_i = wr; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_data_i = data; req_rd_i = rd;
    @(posedge clk);
    @(negedge clk);
    req_ld_i = 1'b0; req_wr_i = 1'b0;
    err1 = err_o; vld1 = bus_valid_o; lat = 1;
    while (!req_ready_o && lat < 500) begin @(negedge clk); lat++; end
    if (!req_ready_o) chk("done_timeout", 32'(req_ready_o), 32'd1);
    wbe = wb_en_o; wba = wb_addr_o; wbd = wb_data_o;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic ld, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, output int lat, output int base,
                         output logic [31:0] wbd);
    logic wbe, err1, vld1;
    logic [4:0] wba;
    int wbc0, erc0, n, nb;
    logic [31:0] wa, bw, rw;
    base = beats.size(); wbc0 = wb_cnt; erc0 = err_cnt;
    do_req(ld, wr, size, uns, addr, data, rd, lat, wbe, err1, vld1, wba, wbd);
    if (size == 2'd3 || (ld && wr)) begin
      chk("illegal_err", 32'(err1), 32'd1);
      chk("illegal_err_width", 32'(err_cnt - erc0), 32'd1);
      chk("illegal_nobeat", 32'(beats.size() - base), 32'd0);
      chk("illegal_valid", 32'(vld1), 32'd0);
      chk("illegal_ready", 32'(lat), 32'd1);
    end else begin
      n = 1 << size;
      nb = (32'(addr[1:0]) + n > 4) ? 2 : 1;
      chk("valid_t1", 32'(vld1), 32'd1);
      chk("err_quiet", 32'(err_cnt - erc0), 32'd0);
      chk("beat_count", 32'(beats.size() - base), 32'(nb));
      if (beats.size() - base == nb)
        for (int i = 0; i < nb; i++) begin
          chk("beat_addr", beats[base+i].addr, {addr[31:2], 2'b00} + 32'(4 * i));
          chk("beat_we", 32'(beats[base+i].we), 32'(wr));
          if (!wr) chk("read_wstrb", 32'(beats[base+i].wstrb), 32'd0);
        end
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
        wa = {addr[31:2], 2'b00} - 32'd4;
        for (int w = 0; w < 3; w++) begin
          for (int b = 0; b < 4; b++) begin
            bw[8*b +: 8] = bus_rd(wa + 32'(4 * w + b));
            rw[8*b +: 8] = ref_rd(wa + 32'(4 * w + b));
          end
          chk("mem_window", bw, rw);
        end
      end else if (rd != 5'd0) begin
        chk("wb_en", 32'(wbe), 32'd1);
        chk("wb_addr", 32'(wba), 32'(rd));
        chk("wb_data", wbd, exp_load(addr, size, uns));
        chk("wb_width", 32'(wb_cnt - wbc0), 32'd1);
      end else begin
        chk("wb_rd0", 32'(wb_cnt - wbc0), 32'd0);
      end
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, base, h0, w0;
    logic [31:0] wbd;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_outs", 32'(|{bus_valid_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
                          wb_en_o, wb_addr_o, wb_data_o, err_o}), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    run_txn(0, 1, 2, 0, 32'h100, 32'hDEADBEEF, 0, lat, base, wbd);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_strb", 32'(beats[base].wstrb), 32'hF);
    chk("sw_data", beats[base].wdata, 32'hDEADBEEF);

    run_txn(0, 1, 0, 0, 32'h203, 32'h000000A5, 0, lat, base, wbd);
    chk("sb_addr", beats[base].addr, 32'h200);
    chk("sb_strb", 32'(beats[base].wstrb), 32'h8);
    chk("sb_data", beats[base].wdata, 32'hA5000000);

    run_txn(0, 1, 2, 0, 32'h100, 32'h44332211, 0, lat, base, wbd);
    run_txn(0, 1, 2, 0, 32'h104, 32'h88776655, 0, lat, base, wbd);
    run_txn(1, 0, 2, 0, 32'h102, 0, 5, lat, base, wbd);
    chk("lw_mis_data", wbd, 32'h66554433);

    run_txn(1, 0, 2, 0, 32'h100, 0, 1, lat, base, wbd);
    chk("lw_latency", 32'(lat), 32'd3);

    run_txn(0, 1, 2, 0, 32'h0, 32'h80123456, 0, lat, base, wbd);
    run_txn(0, 1, 2, 0, 32'h4, 32'h000000FF, 0, lat, base, wbd);
    run_txn(1, 0, 1, 0, 32'h3, 0, 9, lat, base, wbd);
    chk("lh_signed", wbd, 32'hFFFFFF80);
    run_txn(1, 0, 1, 1, 32'h3, 0, 9, lat, base, wbd);
    chk("lhu_zero", wbd, 32'h0000FF80);

    run_txn(0, 1, 2, 0, 32'h105, 32'h11223344, 0, lat, base, wbd);
    chk("ss_latency", 32'(lat), 32'd3);
    chk("ss_strb0", 32'(beats[base].wstrb), 32'hE);
    chk("ss_data0", beats[base].wdata, 32'h22334400);
    chk("ss_strb1", 32'(beats[base+1].wstrb), 32'h1);
    chk("ss_data1", beats[base+1].wdata, 32'h00000011);

    run_txn(0, 1, 2, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 0, lat, base, wbd);
    run_txn(1, 0, 2, 0, 32'hFFFFFFFE, 0, 3, lat, base, wbd);
    chk("wrap_load", wbd, 32'hCAFEF00D);
    run_txn(1, 0, 0, 0, 32'h100, 0, 0, lat, base, wbd);
    run_txn(1, 1, 2, 0, 32'h100, 0, 4, lat, base, wbd);
    run_txn(1, 0, 3, 0, 32'h100, 0, 4, lat, base, wbd);

    // Backpressure: ready held low while the store beat is presented.
    h0 = hold_cnt;
    hold_n = 4; hold_gen++;
    @(negedge clk);
    run_txn(0, 1, 2, 0, 32'h300, 32'h0BADF00D, 0, lat, base, wbd);
    chk("hold_cycles", 32'(hold_cnt - h0 >= 2), 32'd1);
    chk("hold_stable", 32'(hold_bad), 32'd0);

    // Reset while waiting for read data; the late response must be ignored.
    rsp_delay = 4;
    w0 = wb_cnt;
    req_ld_i = 1'b1; req_size_i = 2'd2; req_addr_i = 32'h100; req_rd_i = 5'd7;
    @(negedge clk);
    req_ld_i = 1'b0;
    @(negedge clk);
    chk("rsp0_ready", 32'(req_ready_o), 32'd0);
    chk("rsp0_valid", 32'(bus_valid_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_ready", 32'(req_ready_o), 32'd1);
    chk("midrst_outs", 32'(|{bus_valid_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
                             wb_en_o, wb_addr_o, wb_data_o, err_o}), 32'd0);
    repeat (10) @(negedge clk);
    chk("stale_rvalid_wb", 32'(wb_cnt - w0), 32'd0);
    chk("stale_rvalid_idle", 32'(req_ready_o), 32'd1);
    rsp_delay = 0;

    rand_rdy = 1'b1; rand_lat = 1'b1;
    for (int t = 0; t < 200; t++) begin
      int op;
      logic ld, wr;
      logic [1:0] sz;
      logic [31:0] a;
      op = $urandom_range(0, 19);
      ld = 1'($urandom_range(0, 1));
      wr = ~ld;
      sz = 2'($urandom_range(0, 2));
      if (op == 0) sz = 2'd3;
      if (op == 1) begin ld = 1'b1; wr = 1'b1; end
      a = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                       : 32'h1000 + 32'($urandom_range(0, 31));
      run_txn(ld, wr, sz, 1'($urandom_range(0, 1)), a, $urandom,
              5'($urandom_range(0, 31)), lat, base, wbd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
